tvmix_demod: RTL
================

# tvmix_demod

Composite-video demodulator: the receive-side counterpart of the palette modulator. It takes a stream of composite samples together with the same I/Q colour-carrier values used to generate them. It integrates luma and the I/Q synchronous products over one carrier window and recovers the packed palette entry (luma, imix, qmix). It sits after the composite sample source and feeds palette-match and debug logic with one recovered entry per window.

## Interface
- WIN_LOG2, 2: log2 of samples per integration window (window = 1 carrier period).
- CC_AMP_LOG2, 6: log2 of carrier peak amplitude A; cc_i/cc_q swing ±2^CC_AMP_LOG2.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present this cycle.
- in_sync  in  1  with in_valid: this sample is first of a window.
- video  in  16  unsigned composite sample.
- cc_i  in  16  signed I carrier value for this sample.
- cc_q  in  16  signed Q carrier value for this sample.
- out_valid  out  1  one-cycle pulse: palentry updated.
- palentry  out  32  {luma[15:0], imix[7:0], qmix[7:0]}; imix/qmix two's complement.
- realign  out  1  one-cycle pulse: partial window discarded by in_sync.

## Operation
- Sample counter cnt (WIN_LOG2 bits) advances only on accepted samples (in_valid=1); wraps from 2^WIN_LOG2−1 to 0 without in_sync (free-running windows).
- in_sync with in_valid forces the sample to be index 0. If cnt≠0 at that moment, the partial window is dropped: no out_valid, and realign pulses. in_sync with cnt=0 is a no-op.
- Stage 1 (products): pi = {1'b0,video}·cc_i, pq = {1'b0,video}·cc_q; signed 17×16 → 33 bits. Video, the index-0 flag and the last flag are registered alongside.
- Stage 2 (accumulate): accL (16+WIN_LOG2 unsigned), accI/accQ (33+WIN_LOG2 signed). Index-0 samples load rather than add, so back-to-back windows need no bubble.
- Stage 3 (scale), on last-sample flag:
  - luma = accL >> WIN_LOG2, truncating.
  - imix = accI >>> S, qmix = accQ >>> S, arithmetic (floor), with S = WIN_LOG2 + 2·CC_AMP_LOG2 − 7. Elaboration error if S<0.
  - imix/qmix saturate to [−128, 127].
  - palentry is registered and out_valid pulses.
- palentry holds its value between windows.
- Reset: cnt=0, all accumulators and pipeline valids 0, palentry=0, out_valid=0, realign=0. Reset mid-window discards all in-flight samples; no output from them.

## Timing
- Full throughput: one sample per clock; in_valid gaps are allowed anywhere and only stall cnt.
- Latency: last sample of a window accepted at edge T → accumulators final at T+1 → palentry/out_valid registered at T+2. out_valid is high for exactly the cycle after T+2.
- realign is registered at the edge that accepts the in_sync sample and is high for the following cycle.
- Simultaneous: the window-N output at T+2 and window-N+1 samples in stages 1/2 do not interact.

## Structure
- Package tvmix_pkg:
  - palentry field offsets/widths (LUMA 31:16, IMIX 15:8, QMIX 7:0).
  - default CC_AMP_LOG2.
  - function sat_s8 (signed saturate to 8 bits), shared with the modulator side.
- Sub-module tvmix_demod_acc: parameterised-width signed accumulator with load-on-first/add-otherwise and enable. Instantiated three times (L, I, Q).

## Test plan
All scenarios use default parameters, cc_i sequence 64,0,−64,0 and cc_q sequence 0,64,0,−64.
- Reset: assert rst mid-stream → palentry=0, out_valid=0, realign=0 immediately. After release, the first full window produces the only output.
- Entry 0xF000007F: video 0xF000,0xF07F,0xF000,0xEF81 with in_sync on the first → palentry=0xF000007F, out_valid exactly 2 edges after the 4th sample.
- Negative imix: video 0x0F80,0x1000,0x1080,0x1000 → palentry=0x10008000.
- Saturation: video 0x812C,0x8000,0x7ED4,0x8000 → imix=+300 saturates → palentry=0x80007F00.
- Streaming: three windows back-to-back, then the same three with random in_valid gaps → identical three outputs, one out_valid each.
- Realign: in_sync on the 3rd sample of a window → realign pulse, no out_valid for the partial window. The next 4 samples decode correctly.

Source files
------------

// File: rtl/tvmix_pkg.sv
// Shared definitions for the composite-video palette modulator/demodulator pair.
// Latency: not applicable (types, constants and a combinational helper only).
// Backpressure: not applicable.
package tvmix_pkg;

    // Palette entry layout: {luma[15:0], imix[7:0], qmix[7:0]}
    localparam int LUMA_LSB = 16;
    localparam int LUMA_W   = 16;
    localparam int IMIX_LSB = 8;
    localparam int IMIX_W   = 8;
    localparam int QMIX_LSB = 0;
    localparam int QMIX_W   = 8;

    // Carrier peak amplitude is 2^CC_AMP_LOG2_DEF by default
    localparam int CC_AMP_LOG2_DEF = 6;

    // Input width of the saturator; wide enough for any scaled accumulator
    localparam int SAT_IN_W = 48;

    typedef struct packed {
        logic [LUMA_W-1:0] luma;
        logic [IMIX_W-1:0] imix;
        logic [QMIX_W-1:0] qmix;
    } pal_t;

    // Clamp a signed value to the two's complement 8-bit range [-128, 127]
    function automatic logic [7:0] sat_s8(input logic signed [SAT_IN_W-1:0] x);
        if (x > 48'sd127) begin
            return 8'h7f;
        end else if (x < -48'sd128) begin
            return 8'h80;
        end else begin
            return x[7:0];
        end
    endfunction

endpackage

// File: rtl/tvmix_demod_acc.sv
// Signed accumulator: loads on the first sample of a window, adds otherwise.
// Latency: one clock from din to acc.
// Backpressure: none; en gates the update, acc holds while en is low.
module tvmix_demod_acc #(
    parameter int W = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] acc
);

    // Load restarts the sum so consecutive windows need no idle cycle between them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= load ? din : acc + din;
        end
    end

endmodule

// File: rtl/tvmix_demod.sv
// Composite demodulator: integrates luma and I/Q carrier products over one window, emits palette entry.
// Latency: last window sample accepted at edge T -> palentry/out_valid registered at T+2.
// Backpressure: none; one sample per clock accepted, in_valid gaps only stall the sample counter.
module tvmix_demod
    import tvmix_pkg::*;
#(
    parameter int WIN_LOG2    = 2,
    parameter int CC_AMP_LOG2 = CC_AMP_LOG2_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_sync,
    input  logic [15:0] video,
    input  logic [15:0] cc_i,
    input  logic [15:0] cc_q,
    output logic        out_valid,
    output logic [31:0] palentry,
    output logic        realign
);

    // Sum over 2^WIN_LOG2 samples of video*A*cos has gain 2^(WIN_LOG2+CC_AMP_LOG2-1);
    // the remaining shift maps full-scale chroma onto the 8-bit mix range.
    localparam int S  = WIN_LOG2 + 2 * CC_AMP_LOG2 - 7;
    localparam int LW = 16 + WIN_LOG2;
    localparam int PW = 33;
    localparam int AW = PW + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

    if (S < 0) begin : g_bad_scale
        $error("tvmix_demod: WIN_LOG2 + 2*CC_AMP_LOG2 - 7 must be non-negative");
    end

    logic [WIN_LOG2-1:0]  cnt;
    logic [WIN_LOG2-1:0]  idx;
    logic                 idx_first;
    logic                 idx_last;
    logic signed [PW-1:0] pi_d;
    logic signed [PW-1:0] pq_d;

    logic                 s1_vld;
    logic                 s1_first;
    logic                 s1_last;
    logic [15:0]          s1_video;
    logic signed [PW-1:0] s1_pi;
    logic signed [PW-1:0] s1_pq;

    logic                 s2_last;
    logic signed [LW-1:0] acc_l;
    logic signed [AW-1:0] acc_i;
    logic signed [AW-1:0] acc_q;

    logic signed [SAT_IN_W-1:0] i_sh;
    logic signed [SAT_IN_W-1:0] q_sh;
    pal_t                       pal_q;

    // in_sync forces the current sample to index 0 regardless of the counter
    assign idx       = in_sync ? '0 : cnt;
    assign idx_first = (idx == '0);
    assign idx_last  = (idx == CNT_LAST);

    // Video is treated as a non-negative 17-bit signed operand
    assign pi_d = 33'($signed({1'b0, video})) * 33'($signed(cc_i));
    assign pq_d = 33'($signed({1'b0, video})) * 33'($signed(cc_q));

    // Sample counter and realign pulse; a resync with a partial window in progress flags realign
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            realign <= 1'b0;
        end else begin
            realign <= in_valid & in_sync & (cnt != '0);
            if (in_valid) begin
                cnt <= idx + 1'b1;
            end
        end
    end

    // Stage 1: carrier products with video and window position flags carried alongside
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_video <= '0;
            s1_pi    <= '0;
            s1_pq    <= '0;
        end else begin
            s1_vld   <= in_valid;
            s1_first <= idx_first;
            s1_last  <= idx_last;
            s1_video <= video;
            s1_pi    <= pi_d;
            s1_pq    <= pq_d;
        end
    end

    // Stage 2: window integrators; a dropped partial window is simply overwritten by the next load
    tvmix_demod_acc #(.W(LW)) u_acc_l (
        .clk  (clk),
        .rst  (rst),
        .en   (s1_vld),
        .load (s1_first),
        .din  (LW'(s1_video)),
        .acc  (acc_l)
    );

    tvmix_demod_acc #(.W(AW)) u_acc_i (
        .clk  (clk),
        .rst  (rst),
        .en   (s1_vld),
        .load (s1_first),
        .din  (AW'(s1_pi)),
        .acc  (acc_i)
    );

    tvmix_demod_acc #(.W(AW)) u_acc_q (
        .clk  (clk),
        .rst  (rst),
        .en   (s1_vld),
        .load (s1_first),
        .din  (AW'(s1_pq)),
        .acc  (acc_q)
    );

    // Track when the accumulators hold a complete window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_last <= 1'b0;
        end else begin
            s2_last <= s1_vld & s1_last;
        end
    end

    // Arithmetic shift floors toward minus infinity before saturation
    assign i_sh = SAT_IN_W'(acc_i) >>> S;
    assign q_sh = SAT_IN_W'(acc_q) >>> S;

    // Stage 3: scale and register the entry; it holds between windows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pal_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= s2_last;
            if (s2_last) begin
                pal_q.luma <= acc_l[LW-1:WIN_LOG2];
                pal_q.imix <= sat_s8(i_sh);
                pal_q.qmix <= sat_s8(q_sh);
            end
        end
    end

    assign palentry = pal_q;

endmodule
